mux_tree_pipe: RTL and testbench

//   Parametrised, pipelined N:1 multiplexer (N = 2**SEL_W) for multi-bit channels.

---
 rtl/mux_tree_pipe_if.sv | 28 ++
 rtl/mux_tree_pipe.sv | 88 ++++++++
 tb/tb_mux_tree_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mux_tree_pipe_if.sv
// Handshake/bus bundle for mux_tree_pipe: N = 2**SEL_W channels of WIDTH bits
// on the input side, one WIDTH-bit channel on the output side.
interface mux_tree_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  localparam int N = 1 << SEL_W;

  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  // Source/consumer side: drives channels, select and the downstream ready.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Mux side: consumes channels, produces the selected channel.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree. Each level narrows the channel set by 4
// (or by 2 on the last level when SEL_W is odd) and is registered, so the
// latency equals the number of levels. The whole pipeline advances on a single
// global enable, so a stalled consumer freezes every stage including bubbles.
module mux_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  mux_tree_pipe_if.slave bus
);

  localparam int LEVELS = (SEL_W + 1) / 2;

  logic en;

  // The pipeline moves whenever the last stage is empty or being drained.
  always_comb begin
    en = !bus.out_valid || bus.out_ready;
  end

  assign bus.in_ready = en;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    // Select bits still unresolved when data enters this level.
    localparam int IN_BITS  = SEL_W - 2*l;
    // Radix-4 except a trailing 2:1 level for odd SEL_W.
    localparam int STEP     = (IN_BITS >= 2) ? 2 : 1;
    localparam int OUT_BITS = IN_BITS - STEP;
    localparam int RADIX    = 1 << STEP;
    localparam int IN_CH    = 1 << IN_BITS;
    localparam int OUT_CH   = 1 << OUT_BITS;

    logic [IN_CH*WIDTH-1:0]  d_in;
    logic [IN_BITS-1:0]      s_in;
    logic                    v_in;
    logic [OUT_CH*WIDTH-1:0] d_mux;
    logic [OUT_CH*WIDTH-1:0] d_reg;
    logic                    v_reg;

    if (l == 0) begin : g_src
      assign d_in = bus.in_data;
      assign s_in = bus.in_sel;
      assign v_in = bus.in_valid;
    end else begin : g_src
      assign d_in = g_lvl[l-1].d_reg;
      assign s_in = g_lvl[l-1].g_sel.s_reg;
      assign v_in = g_lvl[l-1].v_reg;
    end

    // Group g gathers channels g*RADIX .. g*RADIX+RADIX-1; low select bits pick within it.
    always_comb begin
      d_mux = '0;
      for (int g = 0; g < OUT_CH; g++) begin
        d_mux[g*WIDTH +: WIDTH] = d_in[(g*RADIX + int'(s_in[STEP-1:0]))*WIDTH +: WIDTH];
      end
    end

    // Stage register: narrowed data and valid, frozen while the consumer stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        d_reg <= '0;
        v_reg <= 1'b0;
      end else if (en) begin
        d_reg <= d_mux;
        v_reg <= v_in;
      end
    end

    if (OUT_BITS > 0) begin : g_sel
      logic [OUT_BITS-1:0] s_reg;

      // Carry the not-yet-used upper select bits alongside their data.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_reg <= '0;
        end else if (en) begin
          s_reg <= s_in[IN_BITS-1:STEP];
        end
      end
    end
  end

  assign bus.out_data  = g_lvl[LEVELS-1].d_reg;
  assign bus.out_valid = g_lvl[LEVELS-1].v_reg;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: an 8-bit/8-channel instance for the main
// scenarios and a 16-bit/16-channel instance for the even-select-width case.
module tb_mux_tree_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mux_tree_pipe_if #(.WIDTH(8),  .SEL_W(3)) bus8  ();
  mux_tree_pipe_if #(.WIDTH(16), .SEL_W(4)) bus16 ();

  mux_tree_pipe #(.WIDTH(8), .SEL_W(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  mux_tree_pipe #(.WIDTH(16), .SEL_W(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the 8-channel instance's handshake inputs for the next edge.
  task automatic applyStimulus(input logic valid, input logic [2:0] sel, input logic ordy);
    bus8.in_valid  = valid;
    bus8.in_sel    = sel;
    bus8.out_ready = ordy;
  endtask

  // Load channel k with 8'h10+k, optionally overriding channel 5.
  task automatic setChannels8(input logic [7:0] ch5);
    for (int k = 0; k < 8; k++) begin
      bus8.in_data[k*8 +: 8] = 8'(16 + k);
    end
    bus8.in_data[5*8 +: 8] = ch5;
  endtask

  // Advance one clock edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    setChannels8(8'h15);
    for (int k = 0; k < 16; k++) begin
      bus16.in_data[k*16 +: 16] = 16'(16'h1000 + k);
    end
    bus16.in_data[9*16 +: 16] = 16'hBEEF;
    bus16.in_sel    = 4'd0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;

    // Reset held two cycles with valid input presented and consumer stalled.
    rst = 1'b1;
    applyStimulus(1'b1, 3'd3, 1'b0);
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(bus8.out_valid), 32'h0);
    checkOutput("rst_out_data",  32'(bus8.out_data),  32'h0);
    checkOutput("rst_in_ready",  32'(bus8.in_ready),  32'h1);
    checkOutput("rst16_out_valid", 32'(bus16.out_valid), 32'h0);
    checkOutput("rst16_out_data",  32'(bus16.out_data),  32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("rst_nothing_emerges", 32'(bus8.out_valid), 32'h0);
    end

    // Sweep all selects back to back; item i appears two edges after capture.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i < 8, 3'(i), 1'b1);
      tick();
      checkOutput("sweep_in_ready", 32'(bus8.in_ready), 32'h1);
      if (i >= 1 && i <= 8) begin
        checkOutput("sweep_valid", 32'(bus8.out_valid), 32'h1);
        checkOutput("sweep_data",  32'(bus8.out_data),  32'(16 + i - 1));
      end else begin
        checkOutput("sweep_idle", 32'(bus8.out_valid), 32'h0);
      end
    end

    // Backpressure: 8'h12 reaches the output, then the consumer stalls.
    applyStimulus(1'b1, 3'd2, 1'b1);
    tick();
    checkOutput("bp_first_latency", 32'(bus8.out_valid), 32'h0);
    applyStimulus(1'b1, 3'd6, 1'b1);
    tick();
    checkOutput("bp_head_valid", 32'(bus8.out_valid), 32'h1);
    checkOutput("bp_head_data",  32'(bus8.out_data),  32'h12);
    applyStimulus(1'b1, 3'd1, 1'b0);
    #1;
    checkOutput("bp_in_ready_low", 32'(bus8.in_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(bus8.out_valid), 32'h1);
      checkOutput("bp_hold_data",  32'(bus8.out_data),  32'h12);
      checkOutput("bp_hold_ready", 32'(bus8.in_ready),  32'h0);
    end
    applyStimulus(1'b1, 3'd1, 1'b1);
    tick();
    checkOutput("bp_rel_data0", 32'(bus8.out_data),  32'h16);
    checkOutput("bp_rel_valid0", 32'(bus8.out_valid), 32'h1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("bp_rel_data1", 32'(bus8.out_data),  32'h11);
    checkOutput("bp_rel_valid1", 32'(bus8.out_valid), 32'h1);
    tick();
    checkOutput("bp_drained", 32'(bus8.out_valid), 32'h0);

    // Single-item bubble on channel 5.
    setChannels8(8'hA5);
    applyStimulus(1'b1, 3'd5, 1'b1);
    tick();
    checkOutput("bubble_t1", 32'(bus8.out_valid), 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("bubble_t2_valid", 32'(bus8.out_valid), 32'h1);
    checkOutput("bubble_t2_data",  32'(bus8.out_data),  32'hA5);
    tick();
    checkOutput("bubble_t3", 32'(bus8.out_valid), 32'h0);
    tick();
    checkOutput("bubble_t4", 32'(bus8.out_valid), 32'h0);
    setChannels8(8'h15);

    // Mid-flight reset: two items loaded, consumer not accepting, then reset.
    applyStimulus(1'b1, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd7, 1'b0);
    tick();
    checkOutput("midrst_loaded", 32'(bus8.out_valid), 32'h1);
    rst = 1'b1;
    applyStimulus(1'b1, 3'd4, 1'b1);
    tick();
    checkOutput("midrst_valid", 32'(bus8.out_valid), 32'h0);
    checkOutput("midrst_data",  32'(bus8.out_data),  32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("midrst_discarded", 32'(bus8.out_valid), 32'h0);
    end

    // Even select width: channels 9 and 15 back to back on the 16-bit instance.
    bus16.in_sel   = 4'd9;
    bus16.in_valid = 1'b1;
    tick();
    checkOutput("even_t1", 32'(bus16.out_valid), 32'h0);
    bus16.in_sel   = 4'd15;
    tick();
    checkOutput("even_valid9", 32'(bus16.out_valid), 32'h1);
    checkOutput("even_data9",  32'(bus16.out_data),  32'hBEEF);
    bus16.in_valid = 1'b0;
    tick();
    checkOutput("even_valid15", 32'(bus16.out_valid), 32'h1);
    checkOutput("even_data15",  32'(bus16.out_data),  32'h100F);
    tick();
    checkOutput("even_drained", 32'(bus16.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
